// File: rtl/spi_pkg.sv
// Shared SPI constants and helpers for the master, the slave responder and their benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int              SPI_FRAME_W    = 32;
    localparam logic [31:0]     SPI_RESET_WORD = 32'hFEDCBA98;
    localparam int              SPI_CNT_W      = 16;
    localparam int              SPI_ABORT_W    = 8;

    // Saturating increment for the abort statistic: sticks at all-ones.
    function automatic logic [SPI_ABORT_W-1:0] spi_sat_inc(input logic [SPI_ABORT_W-1:0] v);
        return (v == '1) ? v : v + SPI_ABORT_W'(1);
    endfunction

endpackage

// File: rtl/spi_slave_responder_if.sv
// Bus bundle between an SPI master (or host bench) and the slave responder.
// Latency: n/a (wires only).
// Backpressure: none; SPI is master-paced, the slave never stalls.
// Signals: CS/MOSI/txData driven by master side; MISO/misoOE, received word,
// valid flag and statistics driven by the slave side.
interface spi_slave_responder_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int CNT_W   = SPI_CNT_W
);
    logic                   CS;
    logic                   MOSI;
    logic                   MISO;
    logic                   misoOE;
    logic [FRAME_W-1:0]     txData;
    logic [FRAME_W-1:0]     rxData;
    logic                   rxValid;
    logic [CNT_W-1:0]       frameCount;
    logic [SPI_ABORT_W-1:0] abortCount;
    logic                   abortFlag;

    modport slave (
        input  CS, MOSI, txData,
        output MISO, misoOE, rxData, rxValid, frameCount, abortCount, abortFlag
    );

    modport master (
        output CS, MOSI, txData,
        input  MISO, misoOE, rxData, rxValid, frameCount, abortCount, abortFlag
    );
endinterface

// File: rtl/spi_bit_counter.sv
// Bit position counter for one SPI frame, wrapping after the last bit.
// Latency: count advances on each SCLK posedge while selected; tc_o is combinational.
// Backpressure: none; deselect (cs_i high) clears the count asynchronously.
// Ports: sclk_i clock, rst_i async active-low reset, cs_i active-low select,
//        cnt_o current bit index, tc_o high on the last bit of a frame.
module spi_bit_counter #(
    parameter  int FRAME_W = 32,
    localparam int CW      = $clog2(FRAME_W)
) (
    input  logic          sclk_i,
    input  logic          rst_i,
    input  logic          cs_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Deselect acts as a second asynchronous clear so a cut-short frame
    // never leaves a stale bit position behind.
    always_ff @(posedge sclk_i or negedge rst_i or posedge cs_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (cs_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);
endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave endpoint: captures MOSI frames, shifts a preloaded/echoed word out on MISO, keeps stats.
// Latency: rxData/rxValid update on the last SCLK posedge of a frame; next MISO MSB valid right after it.
// Backpressure: none; master-paced. txData is sampled only on the frame-completion edge.
// Ports: rst async active-low reset, SCLK SPI clock (posedge), bus slave modport carrying
//        CS/MOSI/MISO/misoOE, txData in, rxData/rxValid out, frameCount/abortCount/abortFlag stats.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                 FRAME_W    = SPI_FRAME_W,
    parameter logic [FRAME_W-1:0] RESET_WORD = SPI_RESET_WORD,
    parameter bit                 LOOPBACK   = 1'b0,
    parameter int                 CNT_W      = SPI_CNT_W
) (
    input  logic                  rst,
    input  logic                  SCLK,
    spi_slave_responder_if.slave  bus
);
    localparam int CW = $clog2(FRAME_W);

    logic [CW-1:0]          bit_cnt;
    logic                   bit_last;

    logic [FRAME_W-1:0]     shreg_q,      shreg_d;
    logic                   partial_q,    partial_d;
    logic [FRAME_W-1:0]     rx_data_q,    rx_data_d;
    logic                   rx_valid_q,   rx_valid_d;
    logic [CNT_W-1:0]       frame_cnt_q,  frame_cnt_d;
    logic [SPI_ABORT_W-1:0] abort_cnt_q,  abort_cnt_d;
    logic                   abort_flag_q, abort_flag_d;
    logic [FRAME_W-1:0]     shifted;

    spi_bit_counter #(
        .FRAME_W (FRAME_W)
    ) u_bit_counter (
        .sclk_i (SCLK),
        .rst_i  (rst),
        .cs_i   (bus.CS),
        .cnt_o  (bit_cnt),
        .tc_o   (bit_last)
    );

    assign shifted = {shreg_q[FRAME_W-2:0], bus.MOSI};

    always_comb begin
        shreg_d      = shreg_q;
        partial_d    = partial_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_cnt_d  = frame_cnt_q;
        abort_cnt_d  = abort_cnt_q;
        abort_flag_d = abort_flag_q;

        if (!bus.CS) begin
            // Bit 0 with bits still pending from before: the previous frame
            // was cut short by deselect. Its received bits are simply dropped
            // and the transmit word keeps shifting where it left off.
            if ((bit_cnt == '0) && partial_q) begin
                abort_cnt_d  = spi_sat_inc(abort_cnt_q);
                abort_flag_d = 1'b1;
            end

            if (bit_last) begin
                rx_data_d   = shifted;
                shreg_d     = LOOPBACK ? shifted : bus.txData;
                rx_valid_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                partial_d   = 1'b0;
            end else begin
                shreg_d   = shifted;
                partial_d = 1'b1;
                if (bit_cnt == '0) begin
                    rx_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge SCLK or negedge rst) begin
        if (!rst) begin
            shreg_q      <= RESET_WORD;
            partial_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_cnt_q  <= '0;
            abort_cnt_q  <= '0;
            abort_flag_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            partial_q    <= partial_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            abort_cnt_q  <= abort_cnt_d;
            abort_flag_q <= abort_flag_d;
        end
    end

    // MISO is combinational from the register so the MSB is on the wire
    // as soon as CS falls, before the first SCLK edge.
    assign bus.MISO       = bus.CS ? 1'b0 : shreg_q[FRAME_W-1];
    assign bus.misoOE     = ~bus.CS;
    assign bus.rxData     = rx_data_q;
    assign bus.rxValid    = rx_valid_q;
    assign bus.frameCount = frame_cnt_q;
    assign bus.abortCount = abort_cnt_q;
    assign bus.abortFlag  = abort_flag_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: table of back-to-back frames plus hand sequences
// for loopback, abort, mid-frame reset and abort-counter saturation.
// Received words are tracked through a queue scoreboard.
module tb_spi_slave_responder;
    import spi_pkg::*;

    localparam int FW = 32;
    localparam int CW = 16;

    logic SCLK;
    logic rst;

    spi_slave_responder_if #(.FRAME_W(FW), .CNT_W(CW)) bus0();
    spi_slave_responder_if #(.FRAME_W(FW), .CNT_W(CW)) bus1();

    spi_slave_responder #(
        .FRAME_W(FW), .RESET_WORD(SPI_RESET_WORD), .LOOPBACK(1'b0), .CNT_W(CW)
    ) dut0 (
        .rst  (rst),
        .SCLK (SCLK),
        .bus  (bus0)
    );

    spi_slave_responder #(
        .FRAME_W(FW), .RESET_WORD(SPI_RESET_WORD), .LOOPBACK(1'b1), .CNT_W(CW)
    ) dut1 (
        .rst  (rst),
        .SCLK (SCLK),
        .bus  (bus1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] mosi;
        logic [31:0] tx;
        logic [31:0] exp_miso;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic mosi);
        bus0.CS = cs;   bus1.CS = cs;
        bus0.MOSI = mosi; bus1.MOSI = mosi;
    endtask

    task automatic set_tx(input logic [31:0] t);
        bus0.txData = t;
        bus1.txData = t;
    endtask

    task automatic pulse();
        #5 SCLK = 1'b1;
        #5 SCLK = 1'b0;
    endtask

    // One full frame with CS held low; MISO is sampled while SCLK is low,
    // just before each rising edge, the way the master samples it.
    task automatic run_frame(input logic [31:0] mosi, output logic [31:0] m0,
                             output logic [31:0] m1, output logic rxv_first);
        exp_q.push_back(mosi);
        m0 = '0; m1 = '0; rxv_first = 1'bx;
        for (int i = 31; i >= 0; i--) begin
            drive(1'b0, mosi[i]);
            #1;
            m0[i] = bus0.MISO;
            m1[i] = bus1.MISO;
            pulse();
            if (i == 31) rxv_first = bus0.rxValid;
        end
    endtask

    // Wait (bounded) for the received word and compare against the scoreboard.
    task automatic sb_check(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            if (bus0.rxValid === 1'b1) seen = 1'b1;
            else #2;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: rxValid never rose, got %b expected 1", name, bus0.rxValid);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: word %h with no expected entry", name, bus0.rxData);
        end else begin
            check(name, bus0.rxData, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0);
        rst = 1'b0;
        #10;
        rst = 1'b1;
        #5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m0, m1, exp_stream;
        logic        rxv;

        vecs[0] = '{mosi: 32'h12345678, tx: 32'hA5A5A5A5, exp_miso: 32'hFEDCBA98, exp_fc: 16'd1};
        vecs[1] = '{mosi: 32'h0F0F0F0F, tx: 32'h3C3C3C3C, exp_miso: 32'hA5A5A5A5, exp_fc: 16'd2};
        vecs[2] = '{mosi: 32'hFFFFFFFF, tx: 32'h00000000, exp_miso: 32'h3C3C3C3C, exp_fc: 16'd3};
        vecs[3] = '{mosi: 32'h00000000, tx: 32'h80000001, exp_miso: 32'h00000000, exp_fc: 16'd4};

        SCLK = 1'b0;
        rst  = 1'b1;
        drive(1'b1, 1'b0);
        set_tx('0);
        #2 rst = 1'b0;
        #10;

        // Reset state
        check("rst_rxData",     bus0.rxData,            32'h0);
        check("rst_rxValid",    32'(bus0.rxValid),      32'h0);
        check("rst_frameCount", 32'(bus0.frameCount),   32'h0);
        check("rst_abortCount", 32'(bus0.abortCount),   32'h0);
        check("rst_abortFlag",  32'(bus0.abortFlag),    32'h0);
        check("rst_MISO_cs_hi", 32'(bus0.MISO),         32'h0);
        check("rst_misoOE",     32'(bus0.misoOE),       32'h0);

        rst = 1'b1;
        #5;
        drive(1'b0, 1'b0);
        #2;
        check("cs_lo_MISO",     32'(bus0.MISO),         32'h1);
        check("cs_lo_misoOE",   32'(bus0.misoOE),       32'h1);
        check("cs_lo_rxValid",  32'(bus0.rxValid),      32'h0);

        // Back-to-back frames, CS held low throughout
        for (int i = 0; i < 4; i++) begin
            set_tx(vecs[i].tx);
            run_frame(vecs[i].mosi, m0, m1, rxv);
            check($sformatf("vec%0d_miso_stream", i), m0, vecs[i].exp_miso);
            check($sformatf("vec%0d_rxValid_first", i), 32'(rxv), 32'h0);
            sb_check($sformatf("vec%0d_rxData", i));
            check($sformatf("vec%0d_rxValid", i), 32'(bus0.rxValid), 32'h1);
            check($sformatf("vec%0d_frameCount", i), 32'(bus0.frameCount), 32'(vecs[i].exp_fc));
        end
        check("next_msb",        32'(bus0.MISO),       32'(vecs[3].tx[31]));
        check("clean_abortCnt",  32'(bus0.abortCount), 32'h0);
        check("clean_abortFlag", 32'(bus0.abortFlag),  32'h0);
        drive(1'b1, 1'b0);
        #2;
        check("cs_hi_MISO",      32'(bus0.MISO),       32'h0);
        check("cs_hi_hold_fc",   32'(bus0.frameCount), 32'd4);

        // Loopback: second MISO stream echoes the first received word
        do_reset();
        set_tx(32'h13579BDF);
        run_frame(32'hDEADBEEF, m0, m1, rxv);
        check("lb_first_stream", m1, SPI_RESET_WORD);
        sb_check("lb_rx0");
        run_frame(32'h00000000, m0, m1, rxv);
        check("lb_echo_stream",  m1, 32'hDEADBEEF);
        check("nolb_tx_stream",  m0, 32'h13579BDF);
        sb_check("lb_rx1");
        check("lb_rxData",       bus1.rxData,            32'h0);
        check("lb_frameCount",   32'(bus1.frameCount),   32'd2);

        // Abort: 10 edges, deselect, then a full frame
        do_reset();
        set_tx('0);
        drive(1'b0, 1'b1);
        repeat (10) pulse();
        drive(1'b1, 1'b0);
        #5;
        run_frame(32'h11223344, m0, m1, rxv);
        exp_stream = (SPI_RESET_WORD << 10) | 32'h3FF;
        check("abort_stream",    m0, exp_stream);
        sb_check("abort_rxData");
        check("abort_count",     32'(bus0.abortCount), 32'd1);
        check("abort_flag",      32'(bus0.abortFlag),  32'h1);
        check("abort_fc",        32'(bus0.frameCount), 32'd1);
        run_frame(32'h55667788, m0, m1, rxv);
        sb_check("post_abort_rx");
        check("sticky_count",    32'(bus0.abortCount), 32'd1);
        check("sticky_flag",     32'(bus0.abortFlag),  32'h1);

        // Mid-frame reset after 16 bits
        drive(1'b0, 1'b1);
        repeat (16) pulse();
        rst = 1'b0;
        #2;
        check("mid_rst_rxData",  bus0.rxData,            32'h0);
        check("mid_rst_fc",      32'(bus0.frameCount),   32'h0);
        check("mid_rst_abort",   32'(bus0.abortCount),   32'h0);
        check("mid_rst_flag",    32'(bus0.abortFlag),    32'h0);
        check("mid_rst_MISO",    32'(bus0.MISO),         32'h1);
        #3 rst = 1'b1;
        #3;
        run_frame(32'hCAFEF00D, m0, m1, rxv);
        check("mid_rst_stream",  m0, SPI_RESET_WORD);
        sb_check("mid_rst_rx");
        check("mid_rst_no_abort", 32'(bus0.abortCount), 32'h0);
        check("mid_rst_fc1",     32'(bus0.frameCount),  32'd1);

        // Abort counter saturation: 257 single-bit frames give 256 aborts
        for (int k = 0; k < 257; k++) begin
            drive(1'b0, 1'b0);
            pulse();
            drive(1'b1, 1'b0);
            #2;
        end
        check("abort_saturate",  32'(bus0.abortCount), 32'd255);
        check("sat_fc_hold",     32'(bus0.frameCount), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave endpoint and the counterpart of the team's SPI master transmitter; one instance is the synthesizable replacement for the behavioural pseudo-slave in the master bench.
- Full-duplex, 32-bit frames, MSB first, clocked only by SCLK.
- Captures each MOSI word and presents it in parallel.
- Shifts a preloaded word (or the echo of the previous word) out on MISO.
- Keeps frame and abort statistics for the host side.

Parameters:
- FRAME_W, 32: bits per frame; shift register, rxData and txData width.
- RESET_WORD, 32'hFEDCBA98: MISO word preloaded by reset.
- LOOPBACK, 0: 1 = next MISO word is the word just received; 0 = next MISO word is txData.
- CNT_W, 16: frameCount width.

Ports:
- rst  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master; all state is updated on the posedge.
- CS  in  1  chip select, active-low.
- MOSI  in  1  serial data from master; sampled on the SCLK posedge.
- MISO  out  1  serial data to master.
- misoOE  out  1  MISO output enable, equal to ~CS.
- txData  in  FRAME_W  next word to transmit; sampled only on the frame-completion edge; must be stable in the SCLK domain.
- rxData  out  FRAME_W  last completely received word.
- rxValid  out  1  high from frame completion until the first edge of the next frame.
- frameCount  out  CNT_W  number of completed frames; wraps at the maximum value.
- abortCount  out  8  number of aborted frames; saturates at 255.
- abortFlag  out  1  sticky; set on the first abort; cleared only by rst.

Behaviour:
- Reset (rst=0, asynchronous):
  - shreg = RESET_WORD, bitCnt = 0, partial = 0.
  - rxData = 0, rxValid = 0, frameCount = 0, abortCount = 0, abortFlag = 0.
- CS=1 asynchronously clears bitCnt (clear = ~rst | CS on bitCnt only). partial, shreg and all outputs hold.
- MISO = shreg[FRAME_W-1] when CS=0, else 0. Combinational, so the MSB is valid before the first edge.
- Posedge SCLK with CS=1: no state change.
- Posedge SCLK with CS=0 and bitCnt < FRAME_W-1:
  - shreg <= {shreg[FRAME_W-2:0], MOSI}; bitCnt++; partial <= 1.
  - If bitCnt == 0, rxValid <= 0.
- Posedge SCLK with CS=0 and bitCnt == FRAME_W-1 (frame completion):
  - rxData <= {shreg[FRAME_W-2:0], MOSI}.
  - shreg <= LOOPBACK ? that same word : txData.
  - rxValid <= 1; frameCount++ (wraps); bitCnt <= 0; partial <= 0.
- Abort detection, on a posedge with CS=0, bitCnt == 0 and partial == 1 (the previous frame was cut short by CS):
  - abortCount++ (saturating); abortFlag <= 1; partial stays 1 because this edge starts a new frame.
  - shreg is not reloaded after an abort: remaining untransmitted bits keep shifting; partial received bits are discarded.
- Latency: rxData and rxValid update on the 32nd posedge of a frame. The new MISO MSB is valid immediately after that edge.
- MISO changes only after posedge SCLK; the master samples it before the next posedge.
- Mid-frame reset: everything returns to reset values immediately. The next CS-low frame starts at bit 0 and is not counted as an abort.
- Back-to-back frames with CS held low: the completion edge leaves bitCnt = 0, so the next 32 edges form a new frame.

Decomposition:
- Shared package spi_pkg holds SPI_FRAME_W = 32 and SPI_RESET_WORD = 32'hFEDCBA98, also used by the master and its bench.
- No sub-module is required.
- An optional small spi_bit_counter (asynchronous CS clear, terminal-count output) is natural if the master reuses it.

Test Plan:
- Reset, then CS low with no SCLK -> MISO=1, rxData=0, rxValid=0, frameCount=0.
- Reset, one 32-bit frame with MOSI=32'h12345678 and txData=32'hA5A5A5A5 -> MISO serial stream = FEDCBA98, rxData=12345678, rxValid=1, frameCount=1, MSB of the next frame on MISO = 1.
- Second frame with MOSI=32'h0F0F0F0F -> MISO stream = A5A5A5A5, rxValid=0 after the first edge then 1, rxData=0F0F0F0F, frameCount=2.
- LOOPBACK=1, frames with MOSI=32'hDEADBEEF then 32'h0 -> second MISO stream = DEADBEEF.
- 10 SCLK edges, CS high, then a full frame with MOSI=32'h11223344 -> abortCount=1, abortFlag=1, rxData=11223344, frameCount=1.
- rst pulse after 16 bits of a frame, then a full frame with MOSI=32'hCAFEF00D -> MISO stream = FEDCBA98, rxData=CAFEF00D, abortCount=0.
